// File: rtl/stft_twiddle_seq_if.sv
// ---------------------------------------------------------------------------
// stft_twiddle_seq_if
// Bundles the control handshake and the lookup/sample-buffer outputs of the
// STFT twiddle sequencer.
//   start, hold      : consumer -> sequencer (window request, stall)
//   busy, done       : sequencer status (busy in RUN/DONE, one-cycle done)
//   cos_en, deg_half : cosine lookup read enable and half-degree angle
//   sample_idx       : sample-buffer read address (n)
//   bin_idx          : current bin (k)
//   bin_first/last   : framing markers for n == 0 / n == N-1
//   *_d1             : the same markers delayed one cycle, aligned with the
//                      lookup's registered output
// Modports: master = consumer side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface stft_twiddle_seq_if #(
    parameter int N_LOG2   = 8,
    parameter int NUM_BINS = 129
);
    localparam int BIN_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;

    logic              start;
    logic              hold;
    logic              busy;
    logic              done;
    logic              cos_en;
    logic [9:0]        deg_half;
    logic [N_LOG2-1:0] sample_idx;
    logic [BIN_W-1:0]  bin_idx;
    logic              bin_first;
    logic              bin_last;
    logic              valid_d1;
    logic [BIN_W-1:0]  bin_idx_d1;
    logic              bin_first_d1;
    logic              bin_last_d1;

    modport master (
        output start, hold,
        input  busy, done, cos_en, deg_half, sample_idx, bin_idx,
               bin_first, bin_last, valid_d1, bin_idx_d1,
               bin_first_d1, bin_last_d1
    );

    modport slave (
        input  start, hold,
        output busy, done, cos_en, deg_half, sample_idx, bin_idx,
               bin_first, bin_last, valid_d1, bin_idx_d1,
               bin_first_d1, bin_last_d1
    );
endinterface

// File: rtl/stft_twiddle_seq.sv
// ---------------------------------------------------------------------------
// stft_twiddle_seq
// Walks every (bin k, sample n) pair of one STFT window, bins outer and
// samples inner, and drives the cosine lookup with a half-degree angle
// derived from the phase (k*n) mod N. The phase is kept in an accumulator
// (adds k per sample, clears per bin) so no multiplier is needed.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : stft_twiddle_seq_if slave modport (see interface header)
// All bus outputs are registered. The registers holding k/n/p always
// describe the pair currently shown on the outputs.
// ---------------------------------------------------------------------------
module stft_twiddle_seq #(
    parameter int N_LOG2   = 8,
    parameter int NUM_BINS = 129
) (
    input  logic               clk,
    input  logic               rst_n,
    stft_twiddle_seq_if.slave  bus
);
    localparam int BIN_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
    localparam int N     = 1 << N_LOG2;
    localparam int PW    = N_LOG2 + 10;

    localparam logic [N_LOG2-1:0] N_MAX  = N_LOG2'(N - 1);
    localparam logic [BIN_W-1:0]  K_MAX  = BIN_W'(NUM_BINS - 1);
    localparam logic [PW-1:0]     HALF_N = PW'(N / 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [BIN_W-1:0]  k_r, k_s;
    logic [N_LOG2-1:0] n_r, n_s;
    logic [N_LOG2-1:0] p_r, p_s;
    logic [N_LOG2-1:0] k_ext_s;
    logic [9:0]        deg_r, deg_s;
    logic              cos_en_r, cos_en_s;
    logic              first_r, first_s;
    logic              last_r, last_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              valid_d1_r;
    logic [BIN_W-1:0]  bin_d1_r;
    logic              first_d1_r;
    logic              last_d1_r;

    // Round-half-up of p*720/N; 720 = 512+128+64+16 built from shifts.
    // (N-1)*720 + N/2 < 720*N, so the result never reaches 720.
    function automatic logic [9:0] deg_of(input logic [N_LOG2-1:0] p);
        logic [PW-1:0] ext;
        logic [PW-1:0] acc;
        ext = PW'(p);
        acc = (ext << 4'd9) + (ext << 4'd7) + (ext << 4'd6) + (ext << 4'd4) + HALF_N;
        return acc[PW-1:N_LOG2];
    endfunction

    // Next-state, next-pair and next-output computation.
    always_comb begin
        state_s  = state_r;
        k_s      = k_r;
        n_s      = n_r;
        p_s      = p_r;
        cos_en_s = 1'b0;
        first_s  = first_r;
        last_s   = last_r;
        done_s   = 1'b0;
        k_ext_s  = N_LOG2'(k_r);

        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s  = ST_RUN;
                    k_s      = '0;
                    n_s      = '0;
                    p_s      = '0;
                    cos_en_s = 1'b1;
                    first_s  = 1'b1;
                    last_s   = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.hold) begin
                    // Pair frozen; enable drops for this cycle only.
                    cos_en_s = 1'b0;
                end else if ((k_r == K_MAX) && (n_r == N_MAX)) begin
                    state_s = ST_DONE;
                    done_s  = 1'b1;
                end else if (n_r == N_MAX) begin
                    k_s      = k_r + BIN_W'(1);
                    n_s      = '0;
                    p_s      = '0;
                    cos_en_s = 1'b1;
                    first_s  = 1'b1;
                    last_s   = 1'b0;
                end else begin
                    // Phase wraps naturally at N because p is N_LOG2 bits.
                    n_s      = n_r + N_LOG2'(1);
                    p_s      = p_r + k_ext_s;
                    cos_en_s = 1'b1;
                    first_s  = 1'b0;
                    last_s   = ((n_r + N_LOG2'(1)) == N_MAX);
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
        deg_s  = deg_of(p_s);
    end

    // State, pair and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            k_r      <= '0;
            n_r      <= '0;
            p_r      <= '0;
            deg_r    <= 10'd0;
            cos_en_r <= 1'b0;
            first_r  <= 1'b0;
            last_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            k_r      <= k_s;
            n_r      <= n_s;
            p_r      <= p_s;
            deg_r    <= deg_s;
            cos_en_r <= cos_en_s;
            first_r  <= first_s;
            last_r   <= last_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
        end
    end

    // One-cycle delayed copies, updated every cycle including hold cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_d1_r <= 1'b0;
            bin_d1_r   <= '0;
            first_d1_r <= 1'b0;
            last_d1_r  <= 1'b0;
        end else begin
            valid_d1_r <= cos_en_r;
            bin_d1_r   <= k_r;
            first_d1_r <= first_r;
            last_d1_r  <= last_r;
        end
    end

    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.cos_en       = cos_en_r;
    assign bus.deg_half     = deg_r;
    assign bus.sample_idx   = n_r;
    assign bus.bin_idx      = k_r;
    assign bus.bin_first    = first_r;
    assign bus.bin_last     = last_r;
    assign bus.valid_d1     = valid_d1_r;
    assign bus.bin_idx_d1   = bin_d1_r;
    assign bus.bin_first_d1 = first_d1_r;
    assign bus.bin_last_d1  = last_d1_r;

endmodule

// File: doc/stft_twiddle_seq.md
# stft_twiddle_seq

Sequences the DFT twiddle angles for one STFT window. On a start pulse it walks every (bin k, sample n) pair, bins outer and samples inner, and drives the cosine lookup stage with a half-degree angle and read enable each cycle. It also emits the matching sample-buffer address and framing markers, both undelayed and delayed one cycle to line up with the lookup's registered output, so the downstream multiply-accumulate can consume cosine and sample in lockstep.

## Interface
Parameters:
- N_LOG2, 8, log2 of window length N; legal range 2..10.
- NUM_BINS, 129, number of bins generated, k = 0..NUM_BINS-1; legal range 1..N.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  one-cycle request to begin a window; honoured only in IDLE.
- hold  in  1  stall from the consumer; freezes sequencing while in RUN.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse at the end of the window.
- cos_en  out  1  read enable to the cosine lookup; high only on valid RUN cycles.
- deg_half  out  10  angle in half-degrees, 0..719, to the cosine lookup.
- sample_idx  out  N_LOG2  current n, the sample-buffer read address.
- bin_idx  out  max(1,clog2(NUM_BINS))  current k.
- bin_first  out  1  high with n == 0.
- bin_last  out  1  high with n == N-1.
- valid_d1  out  1  cos_en delayed one cycle.
- bin_idx_d1  out  as bin_idx  bin_idx delayed one cycle.
- bin_first_d1  out  1  bin_first delayed one cycle.
- bin_last_d1  out  1  bin_last delayed one cycle.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on start.
  - RUN -> DONE after the pair (NUM_BINS-1, N-1) is issued on a non-hold cycle.
  - DONE -> IDLE unconditionally after one cycle.
- Internal phase accumulator p is N_LOG2 bits, equal to (k*n) mod N.
  - Clears to 0 at each new bin.
  - Adds k modulo N (natural wrap) per sample.
  - No multiplier is used.
- deg_half = (p*720 + N/2) >> N_LOG2.
  - Intermediate width is N_LOG2+10 bits.
  - This is round-half-up of p*720/N.
  - With N ≤ 1024 the maximum result is 719, so 720 is never produced.
- Outputs are registered. cos_en, deg_half, sample_idx, bin_idx, bin_first and bin_last change together and always describe the same pair.
- hold in RUN:
  - The pair does not advance.
  - cos_en is 0 and the other outputs hold their values.
  - The lookup then outputs 0 on the following cycle; the consumer must qualify with valid_d1.
- hold is ignored in IDLE and DONE.
- start is ignored while busy; start and hold may both be high, and start is still accepted.
- The *_d1 registers update every cycle, including hold cycles, so valid_d1 = 0 follows each hold cycle.
- Reset, asynchronous and also mid-window:
  - State goes to IDLE.
  - All outputs and the accumulator go to 0, including deg_half = 0, cos_en = 0, all *_d1 = 0 and done = 0.
  - No partial window resumes after reset.

## Timing
- Start accepted at edge t:
  - From t+1, cos_en = 1 with k=0, n=0, deg_half=0, bin_first=1.
  - From t+2, valid_d1 = 1.
- With no hold, a window is exactly NUM_BINS*N consecutive cos_en cycles.
- Cycle after the last pair:
  - cos_en = 0, done = 1, busy = 1 (DONE).
  - valid_d1 = 1 and bin_last_d1 = 1 for the last pair.
- Cycle after that: busy = 0, and a new start is accepted.
  - Minimum start-to-start spacing is NUM_BINS*N + 2 cycles.
- Each hold cycle in RUN adds exactly one cycle to the window.

## Test plan
- Reset check: with N_LOG2=3, assert rst_n low at any time -> all outputs 0 immediately, asynchronously; after release, remain in IDLE with busy=0.
- Sweep with N_LOG2=3, NUM_BINS=5, no hold:
  - k=1 gives deg_half 0,90,180,270,360,450,540,630.
  - k=3 gives 0,270,540,90,360,630,180,450.
  - 40 cos_en cycles total, then done one cycle later.
- Rounding with N_LOG2=8, k=1:
  - n=1 -> deg_half=3.
  - n=255 -> 717.
  - k=128, n=1 -> 360.
  - Over the full window no value exceeds 719.
- Hold: assert hold for 3 cycles mid-bin at n=4 -> pair frozen at n=4, cos_en=0 for 3 cycles, valid_d1=0 for the 3 following cycles, window 3 cycles longer.
- Start while busy: pulse start mid-window and during DONE -> ignored, single done pulse. A start one cycle after DONE is accepted.
- Reset mid-window: at k=2, n=5, assert reset then restart -> sequence restarts at k=0, n=0 with no stale markers in *_d1.
